mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Arbitrates the single unified word memory between the multi-cycle CPU
//  (instruction fetch and lw/sw) and a DMA/debug requester. Sequences each
//  access through a fixed wait-state count and returns a registered response.
//  CPU has priority; a streak limit prevents DMA starvation. The CPU controller
//  holds its current state until cpu_done.
// PARAMETERS
//  AW          32  address width (byte address; word-aligned accesses only)
//  DW          32  data width
//  MEM_LAT     1   memory wait states, range 1..15; the access is held this many cycles
//  STARVE_LIM  4   consecutive contested CPU grants before DMA is forced; range 1..15
// PORTS
//  clk         in   1   clock
//  reset       in   1   asynchronous, active-high
//  cpu_req     in   1   CPU access request; held with we/addr/wdata until cpu_done
//  cpu_we      in   1   1=write, 0=read
//  cpu_addr    in   AW  byte address
//  cpu_wdata   in   DW  write data
//  cpu_gnt     out  1   1-cycle pulse: CPU access accepted
//  cpu_done    out  1   1-cycle pulse: CPU access complete, rdata/err valid
//  dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_done: as cpu_*, DMA side
//  rdata       out  DW  read data of the last completed read
//  err         out  1   valid with *_done: misaligned address, no memory access made
//  busy        out  1   state != IDLE
//  mem_en      out  1   memory access active
//  mem_we      out  1   memory write strobe (qualified by mem_en)
//  mem_addr    out  AW  latched address
//  mem_wdata   out  DW  latched write data
//  mem_rdata   in   DW  memory read data, valid in the last BUSY cycle
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; streak=0; wait counter=0; rdata=0.
//  Reset mid-access abandons the access: mem_en drops immediately, no done is issued.
//  States (encoding 2 bits):
//   IDLE: arbitrate on the sampled reqs. Winner: if dma_req && !cpu_req, DMA. If
//     both requests are high, DMA when streak==STARVE_LIM, else CPU. The winner's
//     we/addr/wdata and the owner are latched. Aligned addr -> BUSY, wait counter
//     loaded with MEM_LAT-1. Misaligned addr (addr[1:0]!=0) -> RESP with err=1.
//   BUSY: mem_en=1, mem_we/addr/wdata from the latches. *_gnt of the owner pulses
//     in the first BUSY cycle only. When counter==0, capture mem_rdata into rdata
//     (reads only) and go to RESP; otherwise decrement.
//   RESP: *_done of the owner=1 for exactly 1 cycle; err is valid. Requests are
//     ignored. Always go to IDLE.
//  Timing: req high in IDLE at cycle 0 -> BUSY in cycles 1..MEM_LAT -> done in
//   cycle MEM_LAT+1. The next grant is sampled no earlier than cycle MEM_LAT+2.
//   A misaligned request gets done+err in cycle 1 and no gnt.
//  Streak: on a CPU grant with dma_req high, streak++ (saturates at STARVE_LIM).
//   Cleared on a DMA grant, or when dma_req is low during IDLE arbitration.
//  rdata is unchanged by writes and by err responses. Request changes during
//   BUSY/RESP have no effect; the latched values are used.
//  Simultaneous reqs at streak<STARVE_LIM: CPU wins and DMA keeps waiting.
// STRUCTURE
//  mem_arb_pkg: state encodings (IDLE/BUSY/RESP), owner encoding (OWN_CPU/OWN_DMA),
//   default parameter constants.
//  Sub-module arb_wait_counter: 4-bit loadable down-counter, outputs zero flag.
//  The FSM, arbitration and latches sit in this module.
// TESTING
//  1 CPU read 0x10, MEM_LAT=1, mem_rdata=0xCAFE -> gnt c1, mem_en c1 only,
//    done+rdata=0xCAFE c2.
//  2 MEM_LAT=3, DMA write 0x20<-0x55 -> mem_en/mem_we c1..c3 with addr 0x20, dma_done c4.
//  3 Both requesters held high, STARVE_LIM=4 -> grant order CPU,CPU,CPU,CPU,DMA,CPU.
//  4 CPU read addr 0x13 -> no mem_en, cpu_done+err c1, rdata unchanged.
//  5 Reset asserted in the 2nd BUSY cycle (MEM_LAT=3) -> mem_en 0 immediately,
//    no done, next req served normally.
//  6 req held high through RESP -> no re-grant in RESP; the next access starts
//    from IDLE only.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified memory port arbiter.
// Holds the FSM and owner encodings used by the arbiter and its wait counter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } arb_owner_t;

    localparam int DEF_AW         = 32;
    localparam int DEF_DW         = 32;
    localparam int DEF_MEM_LAT    = 1;
    localparam int DEF_STARVE_LIM = 4;
    localparam int CNT_W          = 4;

endpackage

// File: rtl/arb_wait_counter.sv
// Loadable 4-bit down-counter that times the memory wait states.
// It stops at zero and flags it, so the FSM can leave BUSY on that flag.
module arb_wait_counter
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified word memory between the CPU and a DMA/debug requester.
// CPU has priority; a streak counter forces a DMA grant after STARVE_LIM contested CPU wins.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int MEM_LAT    = DEF_MEM_LAT,
    parameter int STARVE_LIM = DEF_STARVE_LIM
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_done,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic          dma_done,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic          busy,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] LAT_LOAD   = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(STARVE_LIM);

    arb_state_t       state, next_state;
    arb_owner_t       owner, win_owner;
    logic             we_q, err_q, first_q;
    logic [AW-1:0]    addr_q, win_addr;
    logic [DW-1:0]    wdata_q, rdata_q, win_wdata;
    logic [CNT_W-1:0] streak;
    logic             win_any, win_we, misaligned;
    logic             cnt_load, cnt_dec, cnt_zero;

    // DMA wins only when the CPU is silent or the CPU streak has hit the limit.
    always_comb begin
        win_any   = cpu_req | dma_req;
        win_owner = OWN_CPU;
        if (dma_req && (!cpu_req || (streak == STREAK_MAX))) begin
            win_owner = OWN_DMA;
        end
        win_we    = cpu_we;
        win_addr  = cpu_addr;
        win_wdata = cpu_wdata;
        if (win_owner == OWN_DMA) begin
            win_we    = dma_we;
            win_addr  = dma_addr;
            win_wdata = dma_wdata;
        end
        misaligned = (win_addr[1:0] != 2'b00);
    end

    always_comb begin
        next_state = state;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        case (state)
            IDLE: begin
                if (win_any) begin
                    if (misaligned) begin
                        next_state = RESP;
                    end else begin
                        next_state = BUSY;
                        cnt_load   = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (cnt_zero) begin
                    next_state = RESP;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Requests are only looked at in IDLE; BUSY and RESP run purely from the latches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            owner   <= OWN_CPU;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            first_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            streak  <= '0;
        end else begin
            state   <= next_state;
            first_q <= (state == IDLE) && win_any && !misaligned;
            if (state == IDLE) begin
                if (win_any) begin
                    owner   <= win_owner;
                    we_q    <= win_we;
                    addr_q  <= win_addr;
                    wdata_q <= win_wdata;
                    err_q   <= misaligned;
                end
                if (!dma_req || (win_owner == OWN_DMA)) begin
                    streak <= '0;
                end else if (streak != STREAK_MAX) begin
                    streak <= streak + CNT_W'(1);
                end
            end
            if ((state == BUSY) && cnt_zero && !we_q) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    arb_wait_counter u_wait (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (LAT_LOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    assign busy      = (state != IDLE);
    assign mem_en    = (state == BUSY);
    assign mem_we    = mem_en && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rdata     = rdata_q;
    assign err       = (state == RESP) && err_q;
    assign cpu_gnt   = first_q && (owner == OWN_CPU);
    assign dma_gnt   = first_q && (owner == OWN_DMA);
    assign cpu_done  = (state == RESP) && (owner == OWN_CPU);
    assign dma_done  = (state == RESP) && (owner == OWN_DMA);

endmodule
